// File: rtl/pc_src_bp.sv
// PC-source selector with a direct-mapped table of saturating-counter
// branch predictors. Predicts conditional branches at fetch, resolves them
// in EX, trains the table on every resolution and keeps hit/miss statistics.
module pc_src_bp #(
    parameter int BHT_DEPTH  = 64,
    parameter int CNT_WIDTH  = 2,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [31:0]           if_pc,
    input  logic [31:0]           if_inst,
    input  logic                  ex_valid,
    input  logic [31:0]           ex_pc,
    input  logic [31:0]           ex_inst,
    input  logic                  ex_pred_taken,
    input  logic                  BrEq,
    input  logic                  BrLt,
    output logic                  pred_taken,
    output logic [1:0]            src,
    output logic                  flush,
    output logic [STAT_WIDTH-1:0] br_cnt,
    output logic [STAT_WIDTH-1:0] miss_cnt
);

    localparam int IDX = $clog2(BHT_DEPTH);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
    // Weakly-not-taken: MSB clear, all lower bits set (0 for a 1-bit counter)
    localparam logic [CNT_WIDTH-1:0]  CNT_RESET = CNT_MAX >> 1;
    localparam logic [STAT_WIDTH-1:0] STAT_MAX  = '1;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SRC_PC4    = 2'd0;
    localparam logic [1:0] SRC_EX_TGT = 2'd1;
    localparam logic [1:0] SRC_IF_TGT = 2'd2;
    localparam logic [1:0] SRC_EX_PC4 = 2'd3;

    logic [CNT_WIDTH-1:0]  bht_q [BHT_DEPTH];
    logic [STAT_WIDTH-1:0] br_cnt_q, br_cnt_d;
    logic [STAT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_WIDTH-1:0]  cnt_d;

    logic [IDX-1:0] if_idx, ex_idx;
    logic           if_is_br, ex_is_br, ex_is_jump;
    logic           ex_taken, train, mispredict;
    logic [CNT_WIDTH-1:0] ex_cnt;

    // Conditional branch: opcode 1100011, funct3 010/011 are not branches
    function automatic logic is_branch(input logic [31:0] inst);
        return (inst[6:0] == OP_BRANCH) && (inst[14:13] != 2'b01);
    endfunction

    assign if_idx     = if_pc[IDX+1:2];
    assign ex_idx     = ex_pc[IDX+1:2];
    assign if_is_br   = is_branch(if_inst);
    assign ex_is_br   = is_branch(ex_inst);
    assign ex_is_jump = (ex_inst[6:0] == OP_JAL) || (ex_inst[6:0] == OP_JALR);
    assign ex_cnt     = bht_q[ex_idx];
    assign train      = ex_valid & ex_is_br;
    assign mispredict = train & (ex_taken != ex_pred_taken);

    // Table read is combinational, so a same-cycle EX write is not yet visible
    assign pred_taken = if_valid & if_is_br & bht_q[if_idx][CNT_WIDTH-1];

    // Branch outcome from the comparator flags, chosen by funct3
    always_comb begin
        ex_taken = 1'b0;
        case (ex_inst[14:12])
            3'b000:          ex_taken = BrEq;
            3'b001:          ex_taken = ~BrEq;
            3'b100, 3'b110:  ex_taken = BrLt;
            3'b101, 3'b111:  ex_taken = ~BrLt;
            default:         ex_taken = 1'b0;
        endcase
    end

    // PC mux select and flush; EX redirects take priority over fetch prediction
    always_comb begin
        src   = SRC_PC4;
        flush = 1'b0;
        if (ex_valid && ex_is_jump) begin
            src   = SRC_EX_TGT;
            flush = 1'b1;
        end else if (train && ex_taken && !ex_pred_taken) begin
            src   = SRC_EX_TGT;
            flush = 1'b1;
        end else if (train && !ex_taken && ex_pred_taken) begin
            src   = SRC_EX_PC4;
            flush = 1'b1;
        end else if (pred_taken) begin
            src   = SRC_IF_TGT;
        end
    end

    // Saturating next value for the counter being trained
    always_comb begin
        cnt_d = ex_cnt;
        if (ex_taken) begin
            if (ex_cnt != CNT_MAX) cnt_d = ex_cnt + CNT_WIDTH'(1);
        end else if (ex_cnt != '0) begin
            cnt_d = ex_cnt - CNT_WIDTH'(1);
        end
    end

    // Saturating statistics next values
    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (train && br_cnt_q != STAT_MAX)        br_cnt_d   = br_cnt_q + STAT_WIDTH'(1);
        if (mispredict && miss_cnt_q != STAT_MAX) miss_cnt_d = miss_cnt_q + STAT_WIDTH'(1);
    end

    // Predictor table: reset to weakly-not-taken, trained on resolved branches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CNT_RESET;
        end else if (train) begin
            bht_q[ex_idx] <= cnt_d;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign br_cnt   = br_cnt_q;
    assign miss_cnt = miss_cnt_q;

    // Address and instruction bits the predictor does not look at
    logic unused_bits;
    assign unused_bits = ^{if_pc[31:IDX+2], if_pc[1:0], ex_pc[31:IDX+2], ex_pc[1:0],
                           if_inst[31:15], if_inst[11:7], ex_inst[31:15], ex_inst[11:7]};

endmodule

// File: doc/pc_src_bp.md
# pc_src_bp

Parametrised successor to the combinational PC-source selector: adds a direct-mapped table of saturating-counter branch predictors. Conditional branches are predicted at fetch, resolved in EX from `BrEq`/`BrLt`, and trained on every resolution. The block drives the PC mux select, raises a pipeline flush on redirect, and keeps branch/mispredict statistics. It sits between the IF PC register and the EX branch comparator.

## Interface
- `BHT_DEPTH`, 64: predictor entries; power of two, ≥ 2.
- `CNT_WIDTH`, 2: bits per saturating counter; ≥ 1.
- `STAT_WIDTH`, 32: width of the statistics counters.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_valid`  in  1  fetch slot holds a real instruction.
- `if_pc`  in  32  PC of the fetched instruction.
- `if_inst`  in  32  fetched instruction.
- `ex_valid`  in  1  EX slot holds a real instruction.
- `ex_pc`  in  32  PC of the EX instruction.
- `ex_inst`  in  32  EX instruction.
- `ex_pred_taken`  in  1  `pred_taken` value carried down the pipe with the EX instruction.
- `BrEq`  in  1  EX operands equal.
- `BrLt`  in  1  EX rs1 < rs2; signedness is selected by the comparator.
- `pred_taken`  out  1  fetch prediction for the IF instruction.
- `src`  out  2  PC mux select:
  - 0: IF PC+4.
  - 1: EX ALU target.
  - 2: IF predicted branch target.
  - 3: EX PC+4 (recovery).
- `flush`  out  1  squash the IF and ID instructions.
- `br_cnt`  out  STAT_WIDTH  resolved conditional branches.
- `miss_cnt`  out  STAT_WIDTH  mispredicted conditional branches.

## Operation
- Index: `IDX = log2(BHT_DEPTH)`. The entry is `pc[IDX+1:2]`. There is no tag, so aliasing is allowed.
- Branch decode: opcode `7'b1100011` with funct3 ∈ {000, 001, 100, 101, 110, 111}. funct3 010 and 011 are non-branches.
- Fetch prediction: `pred_taken = if_valid & if_is_branch & counter[MSB]`. The table read is combinational.
- Resolution condition `ex_taken`, by funct3:
  - beq (000): `BrEq`.
  - bne (001): `!BrEq`.
  - blt (100) and bltu (110): `BrLt`.
  - bge (101) and bgeu (111): `!BrLt`.
- `src`/`flush` priority, first match wins:
  1. `ex_valid` & jal (`1101111`) or jalr (`1100111`): src=1, flush=1.
  2. `ex_valid` & branch & `ex_taken` & !`ex_pred_taken`: src=1, flush=1, mispredict.
  3. `ex_valid` & branch & !`ex_taken` & `ex_pred_taken`: src=3, flush=1, mispredict.
  4. `pred_taken`: src=2, flush=0.
  5. Otherwise: src=0, flush=0.
- Training: on `ex_valid` & branch, the entry at `ex_pc` increments if `ex_taken`, else decrements. Counters saturate at all-ones and zero. Non-branches, jal/jalr and invalid slots never train.
- Statistics:
  - `br_cnt` increments on every resolved branch.
  - `miss_cnt` increments on cases 2 and 3.
  - Both saturate at all-ones and never wrap.

## Timing
- `pred_taken`, `src` and `flush` are combinational from inputs and registered state, with zero-cycle latency.
- Table and counter writes take effect at the next rising edge.
- Simultaneous EX write and IF read of the same index: IF sees the pre-update value. The updated value is visible from the following cycle.
- Reset (`rst`=0), asynchronous, at any time including mid-update:
  - Every table entry is set to weakly-not-taken (`{1'b0, {CNT_WIDTH-1{1'b1}}}`; `01` for width 2).
  - `br_cnt` and `miss_cnt` are set to 0.
- During reset the outputs follow the combinational rules using the reset table. With default widths: `pred_taken`=0, and `src`/`flush` depend only on the EX inputs.
- Release of reset is synchronised externally. The first training edge is the first rising `clk` with `rst`=1.
- `CNT_WIDTH`=1 degenerates to a 1-bit last-outcome predictor, whose reset value is 0.

## Test plan
- **Reset:** pulse `rst`=0 mid-stream, then IF beq `32'h08248663` at PC `0x104` → `pred_taken`=0, `src`=0, `br_cnt`=`miss_cnt`=0.
- **Taken mispredict and training:** EX beq `32'h08248663` at `ex_pc`=`0x104`, `BrEq`=1, `ex_pred_taken`=0 → `src`=1, `flush`=1. Next cycle: entry 1 holds `10`, IF at `0x104` gives `pred_taken`=1, `src`=2, and `br_cnt`=`miss_cnt`=1.
- **Saturation and hysteresis:** four taken resolutions at `0x104` → entry holds `11`. One not-taken bge `32'h08565063` (`BrLt`=1) → entry `10`, still predicts taken.
- **Not-taken recovery:** EX bne `32'h08351463`, `BrEq`=1, `ex_pred_taken`=1 → `src`=3, `flush`=1, `miss_cnt`+1, entry decremented.
- **Jumps and non-branches:**
  - jal `32'h000003ef` and jalr `32'h4d508467` in EX → `src`=1, `flush`=1, no table or counter change.
  - lb `32'h00840783` with any `BrEq`/`BrLt` → `src`=0, `flush`=0.
- **Collisions:**
  - Same-cycle EX update and IF lookup at `0x104` → IF sees the old value.
  - EX redirect with IF `pred_taken`=1 → `src`=1 (EX wins).
  - PC `0x204` aliases entry 1 for `BHT_DEPTH`=64.
  - `miss_cnt` preloaded near all-ones via forced stimulus does not wrap.
